// File: rtl/sprite_rom_scheduler.sv
// sprite_rom_scheduler: windowed round-robin arbiter giving four sprite engines burst access to one bitmap ROM.
// Revision: 1.0
`default_nettype none

module sprite_rom_scheduler #(
  parameter int WIN_START = 256,
  parameter int WIN_END   = 308,
  parameter int BURST_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [3:0] req,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] addr2,
  input  logic [7:0] addr3,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [3:0] gnt,
  output logic [7:0] rdata,
  output logic [3:0] rvalid
);

  localparam logic [8:0] WIN_LO    = 9'(WIN_START);
  localparam logic [8:0] WIN_HI    = 9'(WIN_END);
  localparam logic [4:0] BURST_LIM = 5'(BURST_MAX);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [1:0] owner;
  logic [1:0] ptr;
  logic [3:0] cnt;

  logic       win;
  logic       read;
  logic [1:0] sel;
  logic [1:0] cand;
  logic       found;
  logic [7:0] owner_addr;
  logic [4:0] cnt_inc;

  assign win     = (hpos >= WIN_LO) && (hpos <= WIN_HI);
  assign read    = (state == GRANT) && req[owner] && win;
  assign cnt_inc = {1'b0, cnt} + 5'd1;

  // First requester at or after ptr, wrapping mod 4.
  always_comb begin
    sel   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (owner)
      2'd0:    owner_addr = addr0;
      2'd1:    owner_addr = addr1;
      2'd2:    owner_addr = addr2;
      default: owner_addr = addr3;
    endcase
  end

  assign rom_addr = (state == GRANT) ? owner_addr : 8'h00;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      owner  <= 2'd0;
      ptr    <= 2'd0;
      cnt    <= 4'd0;
      gnt    <= 4'b0000;
      rdata  <= 8'h00;
      rvalid <= 4'b0000;
    end else begin
      rvalid <= 4'b0000;
      if (read) begin
        rdata  <= rom_data;
        rvalid <= 4'b0001 << owner;
      end

      if (state == IDLE) begin
        if (win && (req != 4'b0000)) begin
          state <= GRANT;
          owner <= sel;
          cnt   <= 4'd0;
          gnt   <= 4'b0001 << sel;
        end
      end else begin
        // Exit priority: window closed, owner released, burst exhausted.
        if (!win) begin
          state <= IDLE;
          gnt   <= 4'b0000;
          ptr   <= owner;
        end else if (!req[owner]) begin
          state <= IDLE;
          gnt   <= 4'b0000;
          ptr   <= owner + 2'd1;
        end else begin
          cnt <= cnt_inc[3:0];
          if (cnt_inc == BURST_LIM) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            ptr   <= owner + 2'd1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/sprite_rom_scheduler.md
SPRITE_ROM_SCHEDULER -- requirements
Module: sprite_rom_scheduler

Interface
REQ-001 SHALL have parameter WIN_START, default 256, first hpos of the load window (inclusive).
REQ-002 SHALL have parameter WIN_END, default 308, last hpos of the load window (inclusive).
REQ-003 SHALL have parameter BURST_MAX, default 8, range 1..16, maximum reads per grant.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset; 0 sampled on a clk edge resets the block.
REQ-006 SHALL have port hpos  input  9  horizontal pixel position from the sync generator.
REQ-007 SHALL have port req  input  4  per-requester read request; bit k belongs to requester k.
REQ-008 SHALL have ports addr0, addr1, addr2, addr3  input  8 each  bitmap ROM address from requester k.
REQ-009 SHALL have port rom_addr  output  8  address to the shared bitmap ROM.
REQ-010 SHALL have port rom_data  input  8  combinational ROM output for rom_addr.
REQ-011 SHALL have port gnt  output  4  registered one-hot grant; at most one bit set.
REQ-012 SHALL have port rdata  output  8  registered ROM data.
REQ-013 SHALL have port rvalid  output  4  registered one-hot strobe; bit k marks rdata as requester k's.

Function
REQ-014 SHALL compute win = (hpos >= WIN_START) && (hpos <= WIN_END), combinational, with 9-bit unsigned compares.
REQ-015 SHALL implement a two-state FSM, IDLE and GRANT, plus a 2-bit owner, a 2-bit round-robin pointer ptr, and a 4-bit read counter cnt.
REQ-016 In IDLE, with win=1 and req!=0, the block SHALL enter GRANT on the next edge; it SHALL set owner to the first k with req[k]=1, scanning ptr, ptr+1, ... mod 4, and SHALL set cnt=0.
REQ-017 In IDLE, with win=0 or req=0, the block SHALL stay in IDLE and keep gnt=0.
REQ-018 gnt SHALL equal one-hot(owner) in GRANT and 0 in IDLE.
REQ-019 rom_addr SHALL be addr[owner] (combinational mux) in GRANT and 8'h00 in IDLE.
REQ-020 A read SHALL occur in any cycle with state=GRANT, req[owner]=1 and win=1; cnt SHALL then increment.
REQ-021 For each read, the block SHALL capture rom_data into rdata and pulse rvalid[owner]=1 on the following edge (1-cycle latency, 1 cycle wide).
REQ-022 In any cycle without a read, rvalid SHALL be 0 on the next edge and rdata SHALL hold its value.
REQ-023 GRANT->IDLE exits SHALL be evaluated in priority order: (a) win=0: ptr=owner and no read occurs; (b) req[owner]=0: ptr=owner+1 and no read occurs; (c) the read brings cnt to BURST_MAX: ptr=owner+1 and the read completes; (d) otherwise the block SHALL stay in GRANT.
REQ-024 ptr arithmetic SHALL wrap mod 4, so 3+1=0.
REQ-025 Every GRANT->IDLE->GRANT handoff SHALL cost exactly 1 idle cycle with gnt=0.
REQ-026 A requester that already has a grant SHALL NOT gain extra reads when other requests arrive; rotation happens only at exit.
REQ-027 Changes to req bits of non-owners during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-028 An owner changing its addr mid-burst SHALL be honoured cycle by cycle, with no address latching.

Reset
REQ-029 With reset=0 at a clk edge, the block SHALL set state=IDLE, gnt=0, rvalid=0, rdata=8'h00, ptr=0, owner=0 and cnt=0, regardless of the current state, including mid-burst.
REQ-030 Reset SHALL take priority over all other transitions.
REQ-031 An in-flight rvalid SHALL NOT appear on the edge after reset.

Verification
REQ-032 Single requester: req=4'b0010, addr1 stepping 8'h10..8'h17, hpos entering 256, BURST_MAX=8 -> gnt=4'b0010 one cycle after win, 8 rvalid[1] pulses with rdata=ROM[8'h10..8'h17], then IDLE and a re-grant after 1 idle cycle.
REQ-033 Round robin: req=4'b1111 held for the whole window -> grant order 0,1,2,3,0,...; each burst is 8 reads; 1 gnt=0 cycle between bursts.
REQ-034 Window close mid-burst: owner 2 with 3 reads done when hpos goes 308->309 -> no read at hpos 309, gnt=0 next cycle, ptr=2; the next window grants requester 2 first (cnt restarts at 0).
REQ-035 Early release: owner 0 drops req after 5 reads while req[3]=1 -> exactly 5 rvalid[0] pulses, 1 idle cycle, then gnt=4'b1000.
REQ-036 Reset mid-burst: reset=0 for 1 cycle during GRANT owner 1 -> next edge gnt=0, rvalid=0, rdata=8'h00; after release, with req=4'b0011, requester 0 is granted first (ptr=0).
REQ-037 Window boundaries: req=4'b0001 held, hpos sweeping 0..340 -> reads occur only at hpos 257..308; no gnt or rvalid outside 257..309.
